// File: rtl/switch_output_arbiter_if.sv
// switch_output_arbiter_if: requester/downstream bundle for one output-port arbiter.
// slave  = arbiter side (takes head-of-FIFO requests, drives grant and output stage).
// master = requester FIFOs plus downstream sink.
interface switch_output_arbiter_if #(
   parameter int NUM_PORTS = 4,
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 4
);
   logic [NUM_PORTS-1:0]        req_i;
   logic [NUM_PORTS*DATA_W-1:0] data_i;
   logic [NUM_PORTS*ADDR_W-1:0] source_i;
   logic [NUM_PORTS-1:0]        grant_o;
   logic                        valid_out;
   logic [ADDR_W-1:0]           source_out;
   logic [DATA_W-1:0]           data_out;
   logic                        out_ready;
   logic                        drop_o;

   modport master (
      output req_i, data_i, source_i, out_ready,
      input  grant_o, valid_out, source_out, data_out, drop_o
   );

   modport slave (
      input  req_i, data_i, source_i, out_ready,
      output grant_o, valid_out, source_out, data_out, drop_o
   );
endinterface

// File: rtl/switch_output_arbiter.sv
// switch_output_arbiter: round-robin scheduler in front of one switch output port.
// Picks one head-of-FIFO packet among requesting inputs, pops it with a one-cycle
// grant pulse and holds it on a registered valid/ready output stage.
// Optional feature: define SWITCH_ARB_TIMEOUT_EN to discard a packet that has been
// back-pressured for TIMEOUT_CYCLES cycles (pulses drop_o); otherwise SEND waits forever.
module switch_output_arbiter #(
   parameter int NUM_PORTS      = 4,
   parameter int DATA_W         = 8,
   parameter int ADDR_W         = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic                    clk,
   input logic                    rst_n,
   switch_output_arbiter_if.slave io_arb
);
   localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   // The round-robin scan and the timeout compare both need at least two of each.
   if (NUM_PORTS < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("switch_output_arbiter: NUM_PORTS and TIMEOUT_CYCLES must be >= 2");
   end

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t              r_state;
   logic                r_valid;
   logic [DATA_W-1:0]   r_data;
   logic [ADDR_W-1:0]   r_src;
   logic [NUM_PORTS-1:0] r_grant;
   logic [PTR_W-1:0]    r_rr_ptr;

   logic                 w_any;
   logic                 w_found;
   logic                 w_accept;
   logic                 w_load;
   logic [PTR_W-1:0]     w_win;
   logic [PTR_W-1:0]     w_ptr_next;
   logic [NUM_PORTS-1:0] w_win_onehot;
   logic [DATA_W-1:0]    w_win_data;
   logic [ADDR_W-1:0]    w_win_src;

   // Round-robin pick: first requester at or after r_rr_ptr, wrapping at NUM_PORTS.
   always_comb begin
      w_found      = 1'b0;
      w_win        = '0;
      w_win_onehot = '0;
      w_win_data   = '0;
      w_win_src    = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         int idx;
         idx = (int'(r_rr_ptr) + k) % NUM_PORTS;
         if (!w_found && io_arb.req_i[idx]) begin
            w_found           = 1'b1;
            w_win             = PTR_W'(idx);
            w_win_onehot[idx] = 1'b1;
            w_win_data        = io_arb.data_i[idx*DATA_W +: DATA_W];
            w_win_src         = io_arb.source_i[idx*ADDR_W +: ADDR_W];
         end
      end
   end

   assign w_any      = |io_arb.req_i;
   assign w_ptr_next = (int'(w_win) == NUM_PORTS - 1) ? '0 : w_win + PTR_W'(1);
   // A new packet may be taken when the stage is empty or its packet leaves this cycle;
   // a stalled SEND never issues a grant, so FIFOs back up instead.
   assign w_accept   = (r_state == SEND) && r_valid && io_arb.out_ready;
   assign w_load     = w_any && ((r_state == IDLE) || w_accept);

`ifdef SWITCH_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] r_to_cnt;
   logic             r_drop;
   logic             w_timeout;

   // Last stalled cycle before the packet is given up on.
   assign w_timeout = (r_state == SEND) && !io_arb.out_ready &&
                      (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Backpressure counter: counts stalled SEND cycles, clears on accept, drop or leaving SEND.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_to_cnt <= '0;
      end else if ((r_state == SEND) && !io_arb.out_ready && !w_timeout) begin
         r_to_cnt <= r_to_cnt + CNT_W'(1);
      end else begin
         r_to_cnt <= '0;
      end
   end

   assign io_arb.drop_o = r_drop;
`else
   assign io_arb.drop_o = 1'b0;
`endif

   // Scheduler FSM with registered grant pulse and output stage.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_valid  <= 1'b0;
         r_data   <= '0;
         r_src    <= '0;
         r_grant  <= '0;
         r_rr_ptr <= '0;
`ifdef SWITCH_ARB_TIMEOUT_EN
         r_drop   <= 1'b0;
`endif
      end else begin
         r_grant <= '0;
`ifdef SWITCH_ARB_TIMEOUT_EN
         r_drop  <= 1'b0;
`endif
         if (w_load) begin
            // Covers both a fresh start from IDLE and a back-to-back reload in SEND.
            r_state  <= SEND;
            r_valid  <= 1'b1;
            r_data   <= w_win_data;
            r_src    <= w_win_src;
            r_grant  <= w_win_onehot;
            r_rr_ptr <= w_ptr_next;
         end else begin
            case (r_state)
               IDLE: begin
                  r_valid <= 1'b0;
               end
               SEND: begin
                  if (w_accept) begin
                     r_state <= IDLE;
                     r_valid <= 1'b0;
                  end
`ifdef SWITCH_ARB_TIMEOUT_EN
                  else if (w_timeout) begin
                     r_state <= IDLE;
                     r_valid <= 1'b0;
                     r_drop  <= 1'b1;
                  end
`endif
               end
               default: begin
                  r_state <= IDLE;
                  r_valid <= 1'b0;
               end
            endcase
         end
      end
   end

   assign io_arb.grant_o    = r_grant;
   assign io_arb.valid_out  = r_valid;
   assign io_arb.data_out   = r_data;
   assign io_arb.source_out = r_src;

endmodule

// File: tb/tb_switch_output_arbiter.sv
// tb_switch_output_arbiter: FWFT requester FIFOs feeding the arbiter, a packet-level
// reference model checked every cycle, plus directed literal expectations.
module tb_switch_output_arbiter;
   localparam int NP = 4;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam int TO = 16;
   localparam int QD = 1024;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   switch_output_arbiter_if #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW)) bus ();

   switch_output_arbiter #(
      .NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .io_arb(bus.slave)
   );

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- requester FIFOs (first-word-fall-through) ----------------
   logic [DW-1:0] fd [NP][QD];
   int wr [NP];
   int rd [NP];

   initial for (int i = 0; i < NP; i++) begin wr[i] = 0; rd[i] = 0; end

   // Head seen by the arbiter already skips the entry being popped by this cycle's grant.
   always_comb begin
      bus.req_i    = '0;
      bus.data_i   = '0;
      bus.source_i = '0;
      for (int i = 0; i < NP; i++) begin
         if (rd[i] + int'(bus.grant_o[i]) < wr[i]) begin
            bus.req_i[i] = 1'b1;
            bus.data_i[i*DW +: DW] = fd[i][(rd[i] + int'(bus.grant_o[i])) % QD];
         end
         bus.source_i[i*AW +: AW] = AW'(1 << i);
      end
   end

   always @(posedge clk)
      for (int i = 0; i < NP; i++)
         if (bus.grant_o[i]) rd[i] <= rd[i] + 1;

   task automatic push(input int p, input logic [DW-1:0] d);
      fd[p][wr[p] % QD] = d;
      wr[p] = wr[p] + 1;
   endtask

   // ---------------- packet-level reference model ----------------
   function automatic int rr_pick(input logic [NP-1:0] r, input int ptr);
      for (int k = 0; k < NP; k++)
         if (r[(ptr + k) % NP]) return (ptr + k) % NP;
      return -1;
   endfunction

   logic          m_busy = 1'b0;
   logic [DW-1:0] m_data = '0;
   logic [AW-1:0] m_src  = '0;
   logic [NP-1:0] m_grant = '0;
   logic          m_drop = 1'b0;
   int            m_ptr = 0;
   int            m_stall = 0;
   int            mw;

   always_comb mw = rr_pick(bus.req_i, m_ptr);

   always @(posedge clk) begin
      if (!rst_n) begin
         m_busy <= 1'b0; m_data <= '0; m_src <= '0; m_grant <= '0;
         m_drop <= 1'b0; m_ptr <= 0; m_stall <= 0;
      end else begin
         m_grant <= '0;
         m_drop  <= 1'b0;
         if (mw >= 0 && (!m_busy || bus.out_ready)) begin
            m_busy  <= 1'b1;
            m_data  <= bus.data_i[mw*DW +: DW];
            m_src   <= bus.source_i[mw*AW +: AW];
            m_grant <= NP'(1) << mw;
            m_ptr   <= (mw + 1) % NP;
            m_stall <= 0;
         end else if (m_busy && bus.out_ready) begin
            m_busy  <= 1'b0;
            m_stall <= 0;
         end
`ifdef SWITCH_ARB_TIMEOUT_EN
         else if (m_busy && m_stall == TO - 1) begin
            m_busy  <= 1'b0;
            m_drop  <= 1'b1;
            m_stall <= 0;
         end
`endif
         else if (m_busy) begin
            m_stall <= m_stall + 1;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   logic          prev_acc = 1'b0;
   logic [NP-1:0] prev_grant = '0;

   always @(negedge clk) begin
      if (chk_en) begin
         check("valid_out", 32'(bus.valid_out), 32'(m_busy));
         check("grant_o", 32'(bus.grant_o), 32'(m_grant));
         check("drop_o", 32'(bus.drop_o), 32'(m_drop));
         if (m_busy) begin
            check("data_out", 32'(bus.data_out), 32'(m_data));
            check("source_out", 32'(bus.source_out), 32'(m_src));
         end
         check("grant_onehot", 32'($countones(bus.grant_o) <= 1), 32'd1);
         if (prev_grant != '0 && bus.grant_o != '0)
            check("grant_gap", 32'(prev_acc), 32'd1);
      end
      prev_grant <= bus.grant_o;
      prev_acc   <= bus.valid_out && bus.out_ready;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int first_drop;
      int stall_left;
      logic [NP-1:0] exp_g;
      logic [DW-1:0] exp_d;
      bus.out_ready = 1'b1;
      rst_n = 1'b0;
      step(2);
      chk_en = 1'b1;
      check("rst_valid", 32'(bus.valid_out), 32'd0);
      check("rst_grant", 32'(bus.grant_o), 32'd0);
      check("rst_data", 32'(bus.data_out), 32'd0);
      check("rst_source", 32'(bus.source_out), 32'd0);
      check("rst_drop", 32'(bus.drop_o), 32'd0);
      rst_n = 1'b1;
      step(1);

      // single request
      push(0, 8'hA5);
      step(1);
      check("single_grant", 32'(bus.grant_o), 32'h1);
      check("single_valid", 32'(bus.valid_out), 32'd1);
      check("single_data", 32'(bus.data_out), 32'hA5);
      check("single_src", 32'(bus.source_out), 32'h1);
      step(1);
      check("single_idle_valid", 32'(bus.valid_out), 32'd0);
      check("single_idle_grant", 32'(bus.grant_o), 32'd0);

      // round robin, all ports requesting
      pulse_reset();
      for (int p = 0; p < NP; p++) begin
         push(p, 8'(16 * (p + 1)));
         push(p, 8'(16 * (p + 1) + 1));
      end
      for (int k = 0; k < 5; k++) begin
         step(1);
         exp_g = NP'(1) << (k % NP);
         exp_d = 8'(16 * ((k % NP) + 1) + k / NP);
         check("rr_grant", 32'(bus.grant_o), 32'(exp_g));
         check("rr_data", 32'(bus.data_out), 32'(exp_d));
         check("rr_valid", 32'(bus.valid_out), 32'd1);
      end
      step(5);

      // fairness after wrap: pointer left at 3, then ports 0 and 3 request
      pulse_reset();
      push(2, 8'h77);
      step(2);
      push(0, 8'hA0);
      push(3, 8'hB3);
      step(1);
      check("wrap_first_grant", 32'(bus.grant_o), 32'h8);
      check("wrap_first_data", 32'(bus.data_out), 32'hB3);
      step(1);
      check("wrap_second_grant", 32'(bus.grant_o), 32'h1);
      check("wrap_second_data", 32'(bus.data_out), 32'hA0);
      step(2);

      // backpressure for 10 cycles
      pulse_reset();
      bus.out_ready = 1'b0;
      for (int p = 0; p < NP; p++) push(p, 8'(8'hC0 + p));
      step(1);
      check("bp_grant0", 32'(bus.grant_o), 32'h1);
      for (int k = 0; k < 10; k++) begin
         step(1);
         check("bp_no_grant", 32'(bus.grant_o), 32'd0);
         check("bp_data_hold", 32'(bus.data_out), 32'hC0);
         check("bp_src_hold", 32'(bus.source_out), 32'h1);
      end
      bus.out_ready = 1'b1;
      step(1);
      check("bp_release_grant", 32'(bus.grant_o), 32'h2);
      check("bp_release_data", 32'(bus.data_out), 32'hC1);
      step(4);

      // reset in the middle of SEND
      bus.out_ready = 1'b0;
      push(1, 8'h31);
      push(2, 8'h32);
      step(2);
      rst_n = 1'b0;
      step(1);
      check("mid_rst_valid", 32'(bus.valid_out), 32'd0);
      check("mid_rst_grant", 32'(bus.grant_o), 32'd0);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      push(3, 8'h33);
      step(1);
      check("post_rst_grant", 32'(bus.grant_o), 32'h4);
      check("post_rst_data", 32'(bus.data_out), 32'h32);
      step(3);

      // long stall: drop with the timeout feature, indefinite hold without it
      bus.out_ready = 1'b0;
      push(1, 8'h5A);
      step(1);
      check("stall_valid_rise", 32'(bus.valid_out), 32'd1);
`ifdef SWITCH_ARB_TIMEOUT_EN
      first_drop = -1;
      for (int k = 1; k <= 40; k++) begin
         step(1);
         if (bus.drop_o && first_drop < 0) first_drop = k;
      end
      check("timeout_drop_cycle", 32'(first_drop), 32'd16);
      check("timeout_valid_low", 32'(bus.valid_out), 32'd0);
`else
      step(40);
      check("stall_valid_held", 32'(bus.valid_out), 32'd1);
      check("stall_data_held", 32'(bus.data_out), 32'h5A);
`endif
      bus.out_ready = 1'b1;
      step(2);

      // randomized traffic with stalls and occasional resets
      stall_left = 0;
      for (int c = 0; c < 700; c++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         if (stall_left == 0 && $urandom_range(0, 79) == 0) stall_left = $urandom_range(5, 22);
         if (stall_left > 0) begin
            bus.out_ready = 1'b0;
            stall_left--;
         end else begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
         end
         for (int p = 0; p < NP; p++)
            if ($urandom_range(0, 3) == 0 && (wr[p] - rd[p]) < QD - 4)
               push(p, 8'($urandom));
         step(1);
      end
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      step(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/switch_output_arbiter.md
Name: switch_output_arbiter

Overview:
- Per-output-port scheduler for the 4-port switch; one instance sits in front of each output port.
- Shares one output among the head-of-FIFO packets of all input ports targeting it, using round-robin.
- Pops the winning input FIFO with a one-cycle grant pulse and presents the packet on a registered valid/ready output stage.
- Input FIFOs are first-word-fall-through (depth DEPTH from packet_pkg), so request and head data are valid in the same cycle.

Parameters:
- NUM_PORTS, 4, number of requesting input ports.
- DATA_W, 8, packet data width.
- ADDR_W, 4, one-hot source/target field width.
- TIMEOUT_CYCLES, 16, backpressure cycles before a forced drop (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset. One clock; reset is synchronous and active-low.
- req_i  input  NUM_PORTS  bit i: input i's FIFO is non-empty and its head packet targets this output.
- data_i  input  NUM_PORTS*DATA_W  flattened head data; slice i belongs to port i.
- source_i  input  NUM_PORTS*ADDR_W  flattened head source field.
- grant_o  output  NUM_PORTS  one-hot, single-cycle pop pulse to the winning FIFO.
- valid_out  output  1  output packet valid.
- source_out  output  ADDR_W  latched source of the packet being sent.
- data_out  output  DATA_W  latched data of the packet being sent.
- out_ready  input  1  downstream accepts when high together with valid_out.
- drop_o  output  1  single-cycle pulse when a packet is discarded by timeout (tied 0 without the optional feature).

Behaviour:
- Reset values (rst_n low at posedge): state=IDLE, valid_out=0, source_out=0, data_out=0, grant_o=0, rr_ptr=0, drop_o=0, timeout counter=0.
- Reset mid-SEND discards the held packet; no grant is issued during the reset cycle.
- FSM states: IDLE, SEND.
- Arbitration (combinational):
  - winner = first i with req_i[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_PORTS.
  - "load event" = state IDLE with any req_i, or state SEND with valid_out&&out_ready and any req_i.
- On a load event, at the next posedge:
  - data_out/source_out are loaded from the winner's slices.
  - valid_out=1, state=SEND, grant_o=onehot(winner) for exactly that one cycle.
  - rr_ptr=(winner+1) mod NUM_PORTS.
- IDLE with req_i=0: stay IDLE; grant_o=0; valid_out=0.
- SEND:
  - valid_out held high.
  - data_out/source_out stable while out_ready=0.
  - On valid_out&&out_ready with no load event: go to IDLE and set valid_out=0 next cycle.
  - Accept plus load event in the same cycle: back-to-back transfer, valid_out stays high, new packet appears next cycle. Throughput is 1 packet/cycle.
- Latency: req_i rising in IDLE at edge N gives valid_out=1 and a grant pulse at edge N+1.
- Requester rule: the grant pulse pops the FIFO. The arbiter must ignore req_i from the port granted in the previous cycle only if that port's FIFO has since gone empty; requesters deassert req_i combinationally, so no extra masking logic is needed.
- No grant is ever issued while SEND is stalled (out_ready=0), so FIFOs fill and apply their own overflow policy.
- Exactly one grant_o bit may be high in any cycle. It is never high in two consecutive cycles unless a transfer was accepted between them.
- rr_ptr wraps from NUM_PORTS-1 to 0.

Optional Feature:
- Macro: SWITCH_ARB_TIMEOUT_EN.
- Defined:
  - A counter increments each cycle in SEND with out_ready=0 and clears on accept or on leaving SEND.
  - When the count reaches TIMEOUT_CYCLES-1 and out_ready is still 0, the next edge drops the packet: valid_out=0, drop_o pulses 1 for one cycle, state=IDLE.
  - No grant is issued in the drop cycle.
- Undefined: no counter; drop_o constant 0; SEND waits indefinitely.

Test Plan:
- Single request: req_i=4'b0001, data_i[0]=8'hA5, out_ready=1. Required: grant_o=0001 for one cycle; valid_out=1, data_out=A5 at the next edge; IDLE again after acceptance.
- Round-robin: req_i=4'b1111 held, out_ready=1, fresh data per port. Required: grant order 0,1,2,3,0, one per cycle, valid_out continuously high.
- Fairness after wrap: rr_ptr=3 with req_i=4'b1001. Required: port 3 granted first, then port 0.
- Backpressure: out_ready=0 for 10 cycles mid-SEND with req_i=1111. Required: no grant pulses; data_out/source_out unchanged; transfer completes on the first out_ready=1 cycle.
- Reset mid-operation: drop rst_n for one cycle during SEND. Required: valid_out=0, grant_o=0, rr_ptr=0 next cycle; the next request is granted from port 0 priority.
- Timeout (SWITCH_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): hold out_ready=0. Required: drop_o pulses once 16 cycles after valid_out rose, valid_out falls, and without the macro valid_out stays high.
